// File: rtl/obi_uart_pkg.sv
// Shared types and helpers for the UART RX interrupt-condition logic.
package obi_uart_pkg;

    typedef enum logic [1:0] {
        TRIG_1,
        TRIG_4,
        TRIG_8,
        TRIG_14
    } rx_trig_lvl_e;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EXPIRED
    } rx_tout_state_e;

    localparam int unsigned MaxCharBits = 12;

    // Start + data + parity + stop; 1.5 stop bits are counted as 2.
    function automatic logic [3:0] char_bits(input logic [1:0] word_len,
                                             input logic       par_en,
                                             input logic       stop_bits);
        return 4'd7 + {2'b00, word_len} + {3'b000, par_en} + {3'b000, stop_bits};
    endfunction

endpackage

// File: rtl/obi_uart_rx_irq_ctrl.sv
// RX FIFO trigger-level and 16550-style character-timeout interrupt conditions.
module obi_uart_rx_irq_ctrl
    import obi_uart_pkg::*;
#(
    parameter int unsigned FifoDepth        = 16,
    parameter int unsigned CharTimeoutChars = 4,
    parameter int unsigned OversampleRate   = 16,
    localparam int unsigned UsageW          = $clog2(FifoDepth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              baud_tick_i,
    input  logic              fifo_en_i,
    input  logic [1:0]        rx_trig_lvl_i,
    input  logic [1:0]        word_len_i,
    input  logic              par_en_i,
    input  logic              stop_bits_i,
    input  logic [UsageW-1:0] rx_fifo_usage_i,
    input  logic              rx_push_i,
    input  logic              rx_pop_i,
    input  logic              rx_fifo_clr_i,
    output logic              rx_fifo_trigger_o,
    output logic              rx_timeout_o
);

    localparam int unsigned MaxLimit = CharTimeoutChars * MaxCharBits * OversampleRate;
    localparam int unsigned CntW     = $clog2(MaxLimit + 1);

    rx_tout_state_e    state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              trig_q;
    logic              tout_q;

    int unsigned       lvl_raw;
    int unsigned       limit_raw;
    logic [UsageW-1:0] trig_lvl;
    logic [CntW-1:0]   limit;
    logic [CntW:0]     cnt_inc;
    logic              usage_nz;
    logic              activity;

    always_comb begin
        unique case (rx_trig_lvl_e'(rx_trig_lvl_i))
            TRIG_1:  lvl_raw = 1;
            TRIG_4:  lvl_raw = 4;
            TRIG_8:  lvl_raw = 8;
            TRIG_14: lvl_raw = 14;
            default: lvl_raw = 1;
        endcase
        // Small FIFOs could otherwise never reach the upper trigger levels.
        trig_lvl = (lvl_raw > FifoDepth) ? UsageW'(FifoDepth) : UsageW'(lvl_raw);
    end

    always_comb begin
        limit_raw = CharTimeoutChars * OversampleRate
                    * 32'(char_bits(word_len_i, par_en_i, stop_bits_i));
        limit     = CntW'(limit_raw);
    end

    assign cnt_inc  = {1'b0, cnt_q} + (CntW + 1)'(1);
    assign usage_nz = (rx_fifo_usage_i != '0);
    assign activity = rx_push_i | rx_pop_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (usage_nz) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                if (!usage_nz) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (activity) begin
                    cnt_d = '0;
                end else if (baud_tick_i) begin
                    // >= so a mid-count LCR change to a shorter frame still expires.
                    if (cnt_inc >= {1'b0, limit}) begin
                        cnt_d   = limit;
                        state_d = EXPIRED;
                    end else begin
                        cnt_d = cnt_inc[CntW-1:0];
                    end
                end
            end
            EXPIRED: begin
                if (rx_pop_i) begin
                    cnt_d   = '0;
                    state_d = usage_nz ? COUNT : IDLE;
                end else if (rx_push_i) begin
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else if (rx_fifo_clr_i || !fifo_en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= (rx_fifo_usage_i >= trig_lvl);
            tout_q  <= (state_d == EXPIRED);
        end
    end

    assign rx_fifo_trigger_o = trig_q;
    assign rx_timeout_o      = tout_q;

endmodule

// File: tb/tb_obi_uart_rx_irq_ctrl.sv
// Scoreboard bench: the driver queues expected output levels, a negedge monitor checks them.
module tb_obi_uart_rx_irq_ctrl;

    localparam int unsigned UsageW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              baud_tick;
    logic              fifo_en;
    logic [1:0]        rx_trig_lvl;
    logic [1:0]        word_len;
    logic              par_en;
    logic              stop_bits;
    logic [UsageW-1:0] usage;
    logic              push;
    logic              pop;
    logic              clr;
    logic              trig_out;
    logic              tout_out;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;

    string name_q[$];
    logic  [1:0] val_q[$];
    int    cyc_q[$];

    obi_uart_rx_irq_ctrl #(
        .FifoDepth       (16),
        .CharTimeoutChars(4),
        .OversampleRate  (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .baud_tick_i      (baud_tick),
        .fifo_en_i        (fifo_en),
        .rx_trig_lvl_i    (rx_trig_lvl),
        .word_len_i       (word_len),
        .par_en_i         (par_en),
        .stop_bits_i      (stop_bits),
        .rx_fifo_usage_i  (usage),
        .rx_push_i        (push),
        .rx_pop_i         (pop),
        .rx_fifo_clr_i    (clr),
        .rx_fifo_trigger_o(trig_out),
        .rx_timeout_o     (tout_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: outputs are levels, so each queued expectation is due on its own cycle.
    always @(negedge clk) begin
        while (cyc_q.size() != 0 && cyc_q[0] <= cyc) begin
            string     nm;
            logic [1:0] ev;
            nm = name_q.pop_front();
            ev = val_q.pop_front();
            void'(cyc_q.pop_front());
            tests_run++;
            if ({trig_out, tout_out} !== ev) begin
                tests_failed++;
                $display("FAIL %s: got trig=%b tout=%b, want trig=%b tout=%b",
                         nm, trig_out, tout_out, ev[1], ev[0]);
            end
        end
    end

    task automatic expect_out(input string nm, input logic t, input logic o);
        name_q.push_back(nm);
        val_q.push_back({t, o});
        cyc_q.push_back(cyc);
    endtask

    // One clock of stimulus; usage tracks the FIFO fill after this cycle's push/pop.
    task automatic step(input logic p, input logic q, input logic tk);
        push      = p;
        pop       = q;
        baud_tick = tk;
        if (p && !q) usage = usage + 1'b1;
        if (q && !p) usage = usage - 1'b1;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        baud_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; baud_tick = 1'b0; fifo_en = 1'b1; rx_trig_lvl = 2'b01;
        word_len = 2'b11; par_en = 1'b0; stop_bits = 1'b0;
        usage = '0; push = 1'b0; pop = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        expect_out("post_reset_idle", 1'b0, 1'b0);

        // 1: trigger at 4 bytes
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            expect_out("trig_below_lvl", 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        expect_out("trig_at_lvl4", 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        expect_out("trig_hold", 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("trig_drop_usage3", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        expect_out("emptied", 1'b0, 1'b0);

        // 2: 8N1 timeout after 640 ticks, pop clears
        step(1'b1, 1'b0, 1'b0);
        ticks(639);
        expect_out("8n1_tick639", 1'b0, 1'b0);
        ticks(1);
        expect_out("8n1_tick640", 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        expect_out("8n1_pop_clears", 1'b0, 1'b0);
        ticks(700);
        expect_out("idle_no_count", 1'b0, 1'b0);

        // 3: 8E2, activity at tick 700 restarts the 768-tick window
        par_en = 1'b1; stop_bits = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        ticks(699);
        step(1'b1, 1'b1, 1'b1);
        expect_out("8e2_activity_700", 1'b0, 1'b0);
        ticks(767);
        expect_out("8e2_tick767", 1'b0, 1'b0);
        ticks(1);
        expect_out("8e2_tick768", 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        expect_out("8e2_push_leaves_exp", 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("8e2_emptied", 1'b0, 1'b0);

        // 4: push coincident with 640th tick wins
        par_en = 1'b0; stop_bits = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        ticks(639);
        step(1'b1, 1'b0, 1'b1);
        expect_out("push_on_tick640", 1'b0, 1'b0);
        ticks(639);
        expect_out("restart_tick639", 1'b0, 1'b0);
        ticks(1);
        expect_out("restart_tick640", 1'b0, 1'b1);

        // 5: clear with simultaneous push while expired
        rx_trig_lvl = 2'b00;
        step(1'b0, 1'b0, 1'b0);
        expect_out("exp_trig1", 1'b1, 1'b1);
        clr = 1'b1;
        push = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; push = 1'b0; usage = '0;
        expect_out("clr_with_push", 1'b0, 1'b0);
        ticks(700);
        expect_out("clr_idle", 1'b0, 1'b0);

        // 6: FIFO disabled, then reset mid-count
        fifo_en = 1'b0;
        usage = 5'd5;
        for (int i = 0; i < 8; i++) begin
            ticks(250);
            expect_out("fifo_dis", 1'b0, 1'b0);
        end
        fifo_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        expect_out("fifo_en_trig", 1'b1, 1'b0);
        ticks(300);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        expect_out("reset_midcount", 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        ticks(639);
        expect_out("after_rst_tick639", 1'b1, 1'b0);
        ticks(1);
        expect_out("after_rst_tick640", 1'b1, 1'b1);

        for (int i = 0; i < 10 && cyc_q.size() != 0; i++) @(posedge clk);
        if (cyc_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", cyc_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
